fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end replacing the single-cycle PC register and PC-wait logic.
- Owns the fetch PC and issues requests to a variable-latency instruction memory.
- Buffers returned instructions in a DEPTH-entry FIFO and presents {instr, pc, fault} to decode over a valid/ready handshake.
- Decode/execute redirect (branch, jal, jalr) flushes the buffer and discards in-flight stale responses.

Parameters:
- XLEN, 32, address/PC/instruction width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, instruction buffer entries and maximum outstanding requests; DEPTH >= 2, need not be a power of 2.

Ports:
- clk  input  1  clock
- n_rst  input  1  reset, asynchronous, active-low
- redirect_valid  input  1  redirect fetch to redirect_pc this cycle
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (treated as 0)
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address, word aligned
- imem_rsp_valid  input  1  in-order response valid; no backpressure
- imem_rsp_data  input  XLEN  instruction word
- imem_rsp_err  input  1  access fault for this response
- out_valid  output  1  buffered instruction available
- out_ready  input  1  decode consumes
- out_instr  output  XLEN  FIFO head instruction
- out_pc  output  XLEN  PC of out_instr
- out_fault  output  1  fault flag of head entry

Behaviour:
- State:
  - fetch_pc: next address to request.
  - rsp_pc: PC of the next kept response.
  - FIFO of {instr, pc, fault} with count, rd_ptr, wr_ptr.
  - outstanding: in-flight requests, including ones to be dropped.
  - drop_cnt: responses still to be discarded.
  - Counters are $clog2(DEPTH+1) bits.
- Reset (async):
  - fetch_pc = rsp_pc = RESET_VECTOR; count = outstanding = drop_cnt = 0; pointers 0.
  - Outputs: out_valid = 0, imem_req_valid = 0 while n_rst is low.
  - FIFO data contents are don't-care.
- Request:
  - imem_req_valid = (count + outstanding < DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc <= fetch_pc + 4 (mod 2^XLEN); outstanding +1.
  - The first request is valid in the first cycle after n_rst deasserts.
  - Credit rule guarantees the FIFO never overflows.
- Response (imem_rsp_valid):
  - outstanding −1.
  - If drop_cnt > 0: discard, drop_cnt −1.
  - Else: write {rsp_data, rsp_pc, rsp_err} at wr_ptr; rsp_pc += 4; count +1.
  - Latency: request accepted cycle T, response cycle T+L (L ≥ 1), out_valid earliest T+L+1. No FIFO bypass.
- Output:
  - out_valid = (count != 0); out_* = FIFO head.
  - On out_valid && out_ready: rd_ptr advances, count −1.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Pointers wrap from DEPTH−1 to 0.
- Redirect (redirect_valid high, highest priority):
  - An out handshake in the same cycle completes; the consumed instruction counts.
  - All FIFO entries are flushed: count = 0, pointers 0.
  - fetch_pc <= rsp_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - A response arriving in the redirect cycle is discarded.
  - outstanding <= outstanding − rsp_valid.
  - drop_cnt <= outstanding − rsp_valid (new value).
  - No request issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Fault:
  - Stored per entry; fetch continues sequentially after a fault.
  - Decode raises a trap and redirects.
- Request hold: while valid && !ready, imem_req_addr is stable unless a redirect occurs, which withdraws valid for that cycle. The memory model must tolerate this.
- Reset mid-operation: all state is cleared immediately. The bench resets the memory model concurrently, so no stale responses arrive after reset.

Test Plan:
- Reset, ready = 1, L = 1, out_ready = 1, memory holds 32'h0000_0013 at every address → imem_req_addr sequence 0, 4, 8, …; first out_valid 2 cycles after the first request, with out_pc = 0, out_instr = 32'h13; one instruction per cycle thereafter.
- out_ready = 0, L = 1 → exactly 4 requests accepted (addrs 0x0–0xC), then imem_req_valid = 0 and out_valid held with out_pc = 0; release out_ready → out_pc 0, 4, 8, C in order, and requests resume at 0x10.
- L = 3, redirect_pc = 32'h100 with 2 requests outstanding and 1 buffered → FIFO empties, the 2 late responses are dropped, next out_pc = 32'h100, next request addr = 32'h100.
- redirect_pc = 32'h102 → imem_req_addr = 32'h100, out_pc = 32'h100.
- imem_rsp_err = 1 on the response for address 0x8 → out_fault = 1 only on the entry with out_pc = 0x8; entry 0xC follows with out_fault = 0.
- RESET_VECTOR = 32'hFFFF_FFF8 → request addrs FFFF_FFF8, FFFF_FFFC, 0000_0000; assert n_rst low mid-stream with 3 outstanding → out_valid = 0 and imem_req_valid = 0 immediately; after release, first addr = FFFF_FFF8.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited requests
// to a variable-latency memory and buffers in-order responses for decode.
module fetch_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     DEPTH        = 4
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            out_fault
);

   localparam int unsigned     CW      = $clog2(DEPTH + 1);
   localparam int unsigned     PW      = $clog2(DEPTH);
   localparam logic [CW:0]     CREDITS = (CW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            fault;
   } entry_t;

   entry_t          fifo_mem [DEPTH];
   entry_t          head;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] redirect_tgt;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   outstanding_after_rsp;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW:0]     inflight;
   logic            req_fire;
   logic            deq;
   logic            keep;
   logic            unused_pc_lsb;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Buffered entries plus in-flight requests (stale ones included) bound new requests
   assign inflight       = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid = n_rst && (inflight < CREDITS) && !redirect_valid;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_pc_lsb  = ^redirect_pc[1:0];

   assign outstanding_after_rsp = outstanding - CW'(imem_rsp_valid);
   assign keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

   assign head      = fifo_mem[rd_ptr];
   assign out_valid = (count != '0);
   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign out_fault = head.fault;
   assign deq       = out_valid && out_ready;

   // Control state; a redirect flushes the buffer and marks every in-flight response stale
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fetch_pc    <= RESET_VECTOR;
         rsp_pc      <= RESET_VECTOR;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_tgt;
         rsp_pc      <= redirect_tgt;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         outstanding <= outstanding_after_rsp;
         drop_cnt    <= outstanding_after_rsp;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + PC_STEP;
         end
         outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
         if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         if (keep) begin
            rsp_pc <= rsp_pc + PC_STEP;
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (deq) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         count <= count + CW'(keep) - CW'(deq);
      end
   end

   // Buffer storage carries no reset; only the count qualifies its contents
   always_ff @(posedge clk) begin
      if (keep) begin
         fifo_mem[wr_ptr] <= '{instr: imem_rsp_data, pc: rsp_pc, fault: imem_rsp_err};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run scored against
// an epoch-tagged memory model and an expected-instruction queue.
module tb_fetch_unit;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RV    = 32'hFFFF_FFF8;

   logic        clk;
   logic        n_rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_fault;

   fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
      .clk(clk), .n_rst(n_rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_fault(out_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      int          epoch;
      int          due;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   pend_t       pend[$];
   exp_t        expq[$];
   int          epoch;
   int          cyc;
   logic [31:0] exp_req;
   int          lat_min, lat_max;
   bit          const_mem, rand_err, err_en;
   logic [31:0] err_addr;
   int          checks, errors;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      if (const_mem) return 32'h0000_0013;
      return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
   endfunction

   task automatic model_reset();
      pend.delete();
      expq.delete();
      exp_req = RV;
      epoch++;
   endtask

   // Drive one cycle's inputs after the falling edge; memory answers in order
   task automatic drive(input logic rv, input logic [31:0] rp, input logic ordy, input logic rqr);
      @(negedge clk);
      redirect_valid = rv;
      redirect_pc    = rp;
      out_ready      = ordy;
      imem_req_ready = rqr;
      if (n_rst && pend.size() != 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pend[0].data;
         imem_rsp_err   = pend[0].err;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         imem_rsp_err   = 1'($urandom);
      end
      #1;
   endtask

   // Cross the rising edge and update the memory model and expected stream
   task automatic advance();
      logic s_rqv, s_rqr, s_ov, s_ordy, s_rsp, s_rv;
      logic [31:0] s_rp, s_addr;
      pend_t p;
      exp_t  e;
      s_rqv = imem_req_valid; s_rqr = imem_req_ready; s_addr = imem_req_addr;
      s_ov  = out_valid;      s_ordy = out_ready;     s_rsp = imem_rsp_valid;
      s_rv  = redirect_valid; s_rp = redirect_pc;
      @(posedge clk);
      if (s_ov && s_ordy && expq.size() != 0) void'(expq.pop_front());
      if (s_rqv && s_rqr) begin
         p.addr  = s_addr;
         p.data  = instr_of(s_addr);
         p.err   = (err_en && s_addr == err_addr) || (rand_err && $urandom_range(7, 0) == 0);
         p.epoch = epoch;
         p.due   = cyc + int'($urandom_range(lat_max, lat_min));
         pend.push_back(p);
         exp_req = exp_req + 32'd4;
      end
      if (s_rsp && pend.size() != 0) begin
         p = pend.pop_front();
         if (p.epoch == epoch && !s_rv) begin
            e.pc = p.addr; e.instr = p.data; e.fault = p.err;
            expq.push_back(e);
         end
      end
      if (s_rv) begin
         expq.delete();
         epoch++;
         exp_req = s_rp & 32'hFFFF_FFFC;
      end
      cyc++;
   endtask

   task automatic test_reset();
      logic [31:0] got[$];
      logic [31:0] want[3];
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
      @(negedge clk);
      n_rst = 1'b1;
      imem_req_ready = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RV) begin
         errors++; $display("FAIL first_req: got valid %b addr %h expected 1 %h", imem_req_valid, imem_req_addr, RV);
      end
      advance();
      for (int i = 0; i < 10 && got.size() < 3; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         if (imem_req_valid) got.push_back(imem_req_addr);
         advance();
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= got.size()) begin
            errors++; $display("FAIL wrap_addr%0d: got none expected %h", i, want[i]);
         end else if (got[i] !== want[i]) begin
            errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_stream();
      int req_cyc, ov_cyc, n_req;
      logic [31:0] nxt_pc;
      logic [31:0] addrs[$];
      req_cyc = -1; ov_cyc = -1; n_req = 0; nxt_pc = 32'h0;
      const_mem = 1'b1; lat_min = 1; lat_max = 1;
      drive(1'b1, 32'h0, 1'b1, 1'b1);
      advance();
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         if (imem_req_valid) begin
            if (req_cyc < 0) req_cyc = i;
            addrs.push_back(imem_req_addr);
         end
         if (ov_cyc >= 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== nxt_pc) begin
               errors++; $display("FAIL stream_rate: got valid %b pc %h expected 1 %h", out_valid, out_pc, nxt_pc);
            end
            nxt_pc = nxt_pc + 32'd4;
         end else if (out_valid) begin
            ov_cyc = i;
            checks++;
            if (out_pc !== 32'h0 || out_instr !== 32'h13) begin
               errors++; $display("FAIL stream_first: got pc %h instr %h expected 0 13", out_pc, out_instr);
            end
            nxt_pc = 32'h4;
         end
         advance();
      end
      checks++;
      if (ov_cyc < 0 || req_cyc < 0 || ov_cyc - req_cyc != 2) begin
         errors++; $display("FAIL stream_latency: got %0d expected 2", ov_cyc - req_cyc);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= addrs.size() || addrs[i] !== 32'(4 * i)) begin
            errors++; $display("FAIL stream_addr%0d: got %h expected %h", i, (i < addrs.size()) ? addrs[i] : 32'hX, 32'(4 * i));
         end
      end
      const_mem = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] acc[$];
      int n;
      bit got_req;
      n = 0; got_req = 1'b0;
      drive(1'b1, 32'h0, 1'b0, 1'b1);
      advance();
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1);
         if (imem_req_valid) acc.push_back(imem_req_addr);
         advance();
      end
      checks++;
      if (acc.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", acc.size()); end
      for (int i = 0; i < 4 && i < acc.size(); i++) begin
         checks++;
         if (acc[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_addr%0d: got %h expected %h", i, acc[i], 32'(4 * i)); end
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
         errors++; $display("FAIL bp_hold: got req %b valid %b pc %h expected 0 1 0", imem_req_valid, out_valid, out_pc);
      end
      advance();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         if (out_valid && n < 4) begin
            checks++;
            if (out_pc !== 32'(4 * n)) begin errors++; $display("FAIL bp_drain%0d: got %h expected %h", n, out_pc, 32'(4 * n)); end
            n++;
         end
         if (imem_req_valid && !got_req) begin
            got_req = 1'b1;
            checks++;
            if (imem_req_addr !== 32'h10) begin errors++; $display("FAIL bp_resume: got %h expected 00000010", imem_req_addr); end
         end
         advance();
      end
      checks++;
      if (n != 4 || !got_req) begin errors++; $display("FAIL bp_timeout: got %0d drained expected 4", n); end
   endtask

   task automatic test_redirect_drop();
      int n_acc;
      bit reached, seen;
      logic rqr;
      n_acc = 0; reached = 1'b0; seen = 1'b0;
      lat_min = 3; lat_max = 3;
      drive(1'b1, 32'h0, 1'b0, 1'b1);
      advance();
      for (int i = 0; i < 20 && !reached; i++) begin
         rqr = (n_acc < 3);
         drive(1'b0, 32'h0, 1'b0, rqr);
         if (imem_req_valid && rqr) n_acc++;
         advance();
         if (expq.size() == 1 && pend.size() == 2) reached = 1'b1;
      end
      checks++;
      if (!reached) begin errors++; $display("FAIL drop_setup: got %0d buffered %0d pending expected 1 2", expq.size(), pend.size()); end
      drive(1'b1, 32'h100, 1'b0, 1'b1);
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_req_in_redirect: got %b expected 0", imem_req_valid); end
      advance();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_flush: got %b expected 0", out_valid); end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         errors++; $display("FAIL drop_next_req: got %b %h expected 1 00000100", imem_req_valid, imem_req_addr);
      end
      advance();
      for (int i = 0; i < 20 && !seen; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         if (out_valid) begin
            seen = 1'b1;
            checks++;
            if (out_pc !== 32'h100 || out_instr !== instr_of(32'h100)) begin
               errors++; $display("FAIL drop_first_out: got pc %h instr %h expected 00000100 %h", out_pc, out_instr, instr_of(32'h100));
            end
         end
         advance();
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL drop_timeout: got no output expected pc 00000100"); end
   endtask

   task automatic test_misaligned();
      bit got_req, got_out;
      got_req = 1'b0; got_out = 1'b0;
      lat_min = 1; lat_max = 1;
      drive(1'b1, 32'h102, 1'b1, 1'b1);
      advance();
      for (int i = 0; i < 20 && !(got_req && got_out); i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         if (imem_req_valid && !got_req) begin
            got_req = 1'b1;
            checks++;
            if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL misalign_req: got %h expected 00000100", imem_req_addr); end
         end
         if (out_valid && !got_out) begin
            got_out = 1'b1;
            checks++;
            if (out_pc !== 32'h100) begin errors++; $display("FAIL misalign_out: got %h expected 00000100", out_pc); end
         end
         advance();
      end
      checks++;
      if (!(got_req && got_out)) begin errors++; $display("FAIL misalign_timeout: got req %b out %b expected 1 1", got_req, got_out); end
   endtask

   task automatic test_back_to_back();
      bit got_req, got_out;
      got_req = 1'b0; got_out = 1'b0;
      lat_min = 2; lat_max = 2;
      drive(1'b1, 32'h200, 1'b1, 1'b1);
      advance();
      drive(1'b1, 32'h300, 1'b1, 1'b1);
      advance();
      for (int i = 0; i < 20 && !(got_req && got_out); i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         if (imem_req_valid && !got_req) begin
            got_req = 1'b1;
            checks++;
            if (imem_req_addr !== 32'h300) begin errors++; $display("FAIL b2b_req: got %h expected 00000300", imem_req_addr); end
         end
         if (out_valid && !got_out) begin
            got_out = 1'b1;
            checks++;
            if (out_pc !== 32'h300) begin errors++; $display("FAIL b2b_out: got %h expected 00000300", out_pc); end
         end
         advance();
      end
      checks++;
      if (!(got_req && got_out)) begin errors++; $display("FAIL b2b_timeout: got req %b out %b expected 1 1", got_req, got_out); end
   endtask

   task automatic test_fault();
      int seen;
      seen = 0;
      lat_min = 1; lat_max = 1;
      err_en = 1'b1; err_addr = 32'h8;
      drive(1'b1, 32'h0, 1'b1, 1'b1);
      advance();
      for (int i = 0; i < 20 && seen < 4; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         if (out_valid) begin
            checks++;
            if (out_pc !== 32'(4 * seen) || out_fault !== (seen == 2)) begin
               errors++; $display("FAIL fault_entry%0d: got pc %h fault %b expected %h %b", seen, out_pc, out_fault, 32'(4 * seen), (seen == 2));
            end
            seen++;
         end
         advance();
      end
      checks++;
      if (seen != 4) begin errors++; $display("FAIL fault_timeout: got %0d entries expected 4", seen); end
      err_en = 1'b0;
   endtask

   task automatic test_random();
      logic rv, ordy, rqr, exp_rqv;
      logic [31:0] rp;
      lat_min = 1; lat_max = 4; rand_err = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rv   = ($urandom_range(19, 0) == 0);
         rp   = $urandom;
         ordy = ($urandom_range(3, 0) != 0);
         rqr  = ($urandom_range(3, 0) != 0);
         drive(rv, rp, ordy, rqr);
         checks++;
         if (out_valid !== (expq.size() != 0)) begin
            errors++; $display("FAIL rnd_out_valid cyc %0d: got %b expected %b", cyc, out_valid, (expq.size() != 0));
         end
         if (expq.size() != 0) begin
            checks++;
            if (out_pc !== expq[0].pc || out_instr !== expq[0].instr || out_fault !== expq[0].fault) begin
               errors++; $display("FAIL rnd_head cyc %0d: got %h %h %b expected %h %h %b", cyc,
                                  out_pc, out_instr, out_fault, expq[0].pc, expq[0].instr, expq[0].fault);
            end
         end
         exp_rqv = (expq.size() + pend.size() < DEPTH) && !rv;
         checks++;
         if (imem_req_valid !== exp_rqv) begin
            errors++; $display("FAIL rnd_req_valid cyc %0d: got %b expected %b", cyc, imem_req_valid, exp_rqv);
         end
         if (imem_req_valid && exp_rqv) begin
            checks++;
            if (imem_req_addr !== exp_req) begin
               errors++; $display("FAIL rnd_req_addr cyc %0d: got %h expected %h", cyc, imem_req_addr, exp_req);
            end
         end
         advance();
      end
      rand_err = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit reached;
      reached = 1'b0;
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 30 && !reached; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         advance();
         if (pend.size() >= 3) reached = 1'b1;
      end
      checks++;
      if (!reached) begin errors++; $display("FAIL rstmid_setup: got %0d outstanding expected 3", pend.size()); end
      #2;
      n_rst = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_immediate: got valid %b req %b expected 0 0", out_valid, imem_req_valid);
      end
      model_reset();
      repeat (2) @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      imem_req_ready = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RV) begin
         errors++; $display("FAIL rstmid_first_req: got %b %h expected 1 %h", imem_req_valid, imem_req_addr, RV);
      end
      advance();
   endtask

   initial begin
      n_rst = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b0; out_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
      checks = 0; errors = 0; cyc = 0; epoch = 0;
      lat_min = 1; lat_max = 1;
      const_mem = 1'b0; rand_err = 1'b0; err_en = 1'b0; err_addr = 32'h0;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_misaligned();
      test_back_to_back();
      test_fault();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
